// File: rtl/genius_sequence_player_pkg.sv
// rtl/genius_sequence_player_pkg.sv - colour codes, FSM states and LFSR mask for the sequence player
package genius_sequence_player_pkg;

    localparam logic [1:0] COLOR_BLUE   = 2'd0;
    localparam logic [1:0] COLOR_GREEN  = 2'd1;
    localparam logic [1:0] COLOR_RED    = 2'd2;
    localparam logic [1:0] COLOR_YELLOW = 2'd3;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LEAD = 2'd1,
        S_ON   = 2'd2,
        S_OFF  = 2'd3
    } state_t;

    // Enable vector order: {yellow, red, green, blue}
    function automatic logic [3:0] color_onehot(input logic [1:0] c);
        case (c)
            COLOR_BLUE:  return 4'b0001;
            COLOR_GREEN: return 4'b0010;
            COLOR_RED:   return 4'b0100;
            default:     return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/genius_sequence_player_if.sv
// rtl/genius_sequence_player_if.sv - command, read-back and colour-enable bundle of the sequence player
interface genius_sequence_player_if #(
    parameter int IDX_W = 6
);
    logic             PLAY;
    logic             EXTEND;
    logic             CLEAR;
    logic [IDX_W-1:0] RD_IDX;
    logic [1:0]       RD_COLOR;
    logic [IDX_W-1:0] LEN;
    logic             BUSY;
    logic             DONE;
    logic             BLUE_EN;
    logic             GREEN_EN;
    logic             RED_EN;
    logic             YELLOW_EN;

    modport master (
        output PLAY, EXTEND, CLEAR, RD_IDX,
        input  RD_COLOR, LEN, BUSY, DONE, BLUE_EN, GREEN_EN, RED_EN, YELLOW_EN
    );

    modport slave (
        input  PLAY, EXTEND, CLEAR, RD_IDX,
        output RD_COLOR, LEN, BUSY, DONE, BLUE_EN, GREEN_EN, RED_EN, YELLOW_EN
    );
endinterface

// File: rtl/genius_lfsr.sv
// rtl/genius_lfsr.sv - free-running 16-bit Galois LFSR supplying random colour codes
module genius_lfsr
    import genius_sequence_player_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] rnd
);
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= SEED;
        else     lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end

    assign rnd = lfsr[1:0];
endmodule

// File: rtl/genius_sequence_player.sv
// rtl/genius_sequence_player.sv - stores the Genius colour sequence and plays it back in whole video frames
module genius_sequence_player
    import genius_sequence_player_pkg::*;
#(
    parameter int          MAX_LEN    = 32,
    parameter int          IDX_W      = 6,
    parameter int          ON_FRAMES  = 30,
    parameter int          OFF_FRAMES = 15,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic                     VGA_VS,
    genius_sequence_player_if.slave  bus
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int FW = $clog2(ON_FRAMES + OFF_FRAMES + 1);
    localparam logic [IDX_W-1:0] LEN_MAX  = IDX_W'(MAX_LEN);
    localparam logic [FW-1:0]    ON_LAST  = FW'(ON_FRAMES - 1);
    localparam logic [FW-1:0]    OFF_LAST = FW'(OFF_FRAMES - 1);

    logic [1:0]       seq [MAX_LEN];
    logic [IDX_W-1:0] len_q;
    logic [1:0]       rnd;
    state_t           state, state_n;
    logic [FW-1:0]    fcnt, fcnt_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [3:0]       en_q, en_n;
    logic             done_q, done_n;
    logic             vs_s1, vs_s2, vs_d, tick;
    logic             idle, cmd_clear, cmd_extend, cmd_play;

    genius_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (CLOCK_50),
        .rst (RESET),
        .rnd (rnd)
    );

    // VGA_VS is from another clock domain: 2-FF sync, then registered falling-edge pulse
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
            vs_d  <= 1'b1;
            tick  <= 1'b0;
        end else begin
            vs_s1 <= VGA_VS;
            vs_s2 <= vs_s1;
            vs_d  <= vs_s2;
            tick  <= vs_d & ~vs_s2;
        end
    end

    assign idle       = (state == S_IDLE);
    assign cmd_clear  = idle & bus.CLEAR;
    assign cmd_extend = idle & ~bus.CLEAR & bus.EXTEND;
    assign cmd_play   = idle & ~bus.CLEAR & ~bus.EXTEND & bus.PLAY;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            len_q <= '0;
            for (int i = 0; i < MAX_LEN; i++) seq[i] <= 2'b00;
        end else if (cmd_clear) begin
            len_q <= '0;
        end else if (cmd_extend && len_q != LEN_MAX) begin
            seq[len_q[AW-1:0]] <= rnd;
            len_q              <= len_q + IDX_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state  <= S_IDLE;
            fcnt   <= '0;
            idx    <= '0;
            en_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            fcnt   <= fcnt_n;
            idx    <= idx_n;
            en_q   <= en_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        idx_n   = idx;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_play) begin
                    if (len_q != '0) begin
                        state_n = S_LEAD;
                        fcnt_n  = '0;
                        idx_n   = '0;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            S_LEAD: begin
                if (tick) begin
                    if (fcnt == OFF_LAST) begin
                        state_n = S_ON;
                        fcnt_n  = '0;
                    end else begin
                        fcnt_n = fcnt + FW'(1);
                    end
                end
            end
            S_ON: begin
                if (tick) begin
                    if (fcnt == ON_LAST) begin
                        state_n = S_OFF;
                        fcnt_n  = '0;
                    end else begin
                        fcnt_n = fcnt + FW'(1);
                    end
                end
            end
            S_OFF: begin
                if (tick) begin
                    if (fcnt == OFF_LAST) begin
                        fcnt_n = '0;
                        if (idx == len_q - IDX_W'(1)) begin
                            state_n = S_IDLE;
                            done_n  = 1'b1;
                        end else begin
                            idx_n   = idx + IDX_W'(1);
                            state_n = S_ON;
                        end
                    end else begin
                        fcnt_n = fcnt + FW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Enables follow the next state so they are lit for exactly the cycles spent in ON
        en_n = (state_n == S_ON) ? color_onehot(seq[idx_n[AW-1:0]]) : 4'b0000;
    end

    assign bus.RD_COLOR  = (bus.RD_IDX < LEN_MAX) ? seq[bus.RD_IDX[AW-1:0]] : 2'b00;
    assign bus.LEN       = len_q;
    assign bus.BUSY      = ~idle;
    assign bus.DONE      = done_q;
    assign bus.BLUE_EN   = en_q[0];
    assign bus.GREEN_EN  = en_q[1];
    assign bus.RED_EN    = en_q[2];
    assign bus.YELLOW_EN = en_q[3];
endmodule

// File: tb/tb_genius_sequence_player.sv
// tb/tb_genius_sequence_player.sv - directed self-checking bench for genius_sequence_player
module tb_genius_sequence_player;
    localparam int          MAX_LEN    = 32;
    localparam int          IDX_W      = 6;
    localparam int          ON_FRAMES  = 2;
    localparam int          OFF_FRAMES = 1;
    localparam logic [15:0] SEED       = 16'hACE1;

    logic CLOCK_50 = 1'b0;
    logic RESET    = 1'b1;
    logic VGA_VS   = 1'b1;

    genius_sequence_player_if #(.IDX_W(IDX_W)) bus ();

    genius_sequence_player #(
        .MAX_LEN    (MAX_LEN),
        .IDX_W      (IDX_W),
        .ON_FRAMES  (ON_FRAMES),
        .OFF_FRAMES (OFF_FRAMES),
        .LFSR_SEED  (SEED)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .VGA_VS   (VGA_VS),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // One-cycle-low VS pulse every 20 clocks, changed 3 ns after the edge
    initial begin
        forever begin
            repeat (19) @(posedge CLOCK_50);
            #3 VGA_VS = 1'b0;
            @(posedge CLOCK_50);
            #3 VGA_VS = 1'b1;
        end
    end

    // Reference LFSR: seed on reset, Galois right shift with mask B400 otherwise
    logic [15:0] m_lfsr;
    always @(posedge CLOCK_50)
        m_lfsr <= RESET ? SEED : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));

    int          vectors = 0;
    int          miscompares = 0;
    logic [1:0]  exp_col [MAX_LEN];
    int          nseg;
    logic [3:0]  seg_val [16];
    int          seg_len [16];
    bit          got_done;
    int          multi;
    bit          vs_seen;
    bit          done_any;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] en_vec();
        return {bus.YELLOW_EN, bus.RED_EN, bus.GREEN_EN, bus.BLUE_EN};
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

    task automatic rd_check(input int i, input logic [1:0] e, input string tag);
        bus.RD_IDX = IDX_W'(i);
        step();
        check($sformatf("%s%0d", tag, i), 32'(bus.RD_COLOR), 32'(e));
    endtask

    task automatic push(input logic [3:0] v, input int l);
        if (nseg < 16) begin
            seg_val[nseg] = v;
            seg_len[nseg] = l;
        end
        nseg++;
    endtask

    // Splits the enable stream into runs of equal value until DONE or the budget expires
    task automatic monitor(input int budget);
        logic [3:0] cur, e;
        int run;
        nseg = 0;
        multi = 0;
        got_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            seg_val[i] = 4'bxxxx;
            seg_len[i] = -1;
        end
        cur = en_vec();
        run = 0;
        for (int c = 0; c < budget; c++) begin
            if (bus.DONE === 1'b1) begin
                got_done = 1'b1;
                break;
            end
            e = en_vec();
            if ($countones(e) > 1) multi++;
            if (e !== cur) begin
                push(cur, run);
                cur = e;
                run = 0;
            end
            run++;
            step();
        end
        push(cur, run);
    endtask

    initial begin
        bus.PLAY   = 1'b0;
        bus.EXTEND = 1'b0;
        bus.CLEAR  = 1'b0;
        bus.RD_IDX = '0;
        repeat (3) step();
        RESET = 1'b0;

        // T1 reset state
        check("t1_len",  32'(bus.LEN),  0);
        check("t1_busy", 32'(bus.BUSY), 0);
        check("t1_done", 32'(bus.DONE), 0);
        check("t1_en",   32'(en_vec()), 0);
        for (int i = 0; i < MAX_LEN; i++) rd_check(i, 2'b00, "t1_rd");

        // T2 three spaced EXTENDs
        for (int k = 0; k < 3; k++) begin
            bus.EXTEND = 1'b1;
            exp_col[k] = m_lfsr[1:0];
            step();
            bus.EXTEND = 1'b0;
            check($sformatf("t2_len%0d", k), 32'(bus.LEN), 32'(k + 1));
            repeat (4) step();
        end
        for (int k = 0; k < 3; k++) rd_check(k, exp_col[k], "t2_rd");

        // T3 playback of three steps
        bus.PLAY = 1'b1;
        step();
        bus.PLAY = 1'b0;
        check("t3_busy_rise", 32'(bus.BUSY), 1);
        monitor(400);
        check("t3_done_seen",    32'(got_done), 1);
        check("t3_busy_at_done", 32'(bus.BUSY), 0);
        check("t3_onehot",       32'(multi), 0);
        check("t3_nseg",         32'(nseg), 7);
        check("t3_lead_dark",    32'(seg_val[0]), 0);
        check("t3_lead_len_ok",  32'(seg_len[0] >= 1 && seg_len[0] <= 20), 1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t3_col%0d", k),     32'(seg_val[1 + 2 * k]), 32'(oh(exp_col[k])));
            check($sformatf("t3_on_len%0d", k),  32'(seg_len[1 + 2 * k]), 40);
            check($sformatf("t3_dark%0d", k),    32'(seg_val[2 + 2 * k]), 0);
            check($sformatf("t3_off_len%0d", k), 32'(seg_len[2 + 2 * k]), 20);
        end
        step();
        check("t3_done_fall", 32'(bus.DONE), 0);
        check("t3_busy_idle", 32'(bus.BUSY), 0);

        // T4 CLEAR then PLAY with empty sequence
        bus.CLEAR = 1'b1;
        step();
        bus.CLEAR = 1'b0;
        check("t4_len", 32'(bus.LEN), 0);
        bus.PLAY = 1'b1;
        step();
        bus.PLAY = 1'b0;
        check("t4_done",      32'(bus.DONE), 1);
        check("t4_busy",      32'(bus.BUSY), 0);
        check("t4_en",        32'(en_vec()), 0);
        step();
        check("t4_done_fall", 32'(bus.DONE), 0);
        check("t4_busy_after", 32'(bus.BUSY), 0);
        check("t4_en_after",  32'(en_vec()), 0);

        // T5 saturation at MAX_LEN
        for (int k = 0; k < 33; k++) begin
            bus.EXTEND = 1'b1;
            if (k < MAX_LEN) exp_col[k] = m_lfsr[1:0];
            step();
        end
        bus.EXTEND = 1'b0;
        check("t5_len_sat", 32'(bus.LEN), 32);
        for (int k = 0; k < MAX_LEN; k++) rd_check(k, exp_col[k], "t5_rd");

        // Align PLAY to the VS phase so lead length is known exactly
        vs_seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (VGA_VS === 1'b0) begin
                vs_seen = 1'b1;
                break;
            end
            step();
        end
        check("t5_vs_seen", 32'(vs_seen), 1);
        repeat (5) step();
        bus.PLAY = 1'b1;
        step();
        bus.PLAY = 1'b0;
        check("t5_busy", 32'(bus.BUSY), 1);
        bus.CLEAR = 1'b1;
        step();
        bus.CLEAR = 1'b0;
        check("t5_len_clear_busy", 32'(bus.LEN), 32);
        bus.EXTEND = 1'b1;
        step();
        bus.EXTEND = 1'b0;
        check("t5_len_ext_busy", 32'(bus.LEN), 32);
        bus.PLAY = 1'b1;
        step();
        bus.PLAY = 1'b0;
        check("t5_busy_play_busy", 32'(bus.BUSY), 1);
        monitor(90);
        check("t5_no_done",  32'(got_done), 0);
        check("t5_nseg",     32'(nseg), 4);
        check("t5_lead",     32'(seg_len[0]), 14);
        check("t5_col0",     32'(seg_val[1]), 32'(oh(exp_col[0])));
        check("t5_on_len0",  32'(seg_len[1]), 40);
        check("t5_dark0",    32'(seg_val[2]), 0);
        check("t5_off_len0", 32'(seg_len[2]), 20);
        check("t5_col1",     32'(seg_val[3]), 32'(oh(exp_col[1])));
        check("t5_len_keep", 32'(bus.LEN), 32);

        // T6 reset while a colour is lit
        check("t6_lit_before", 32'(en_vec()), 32'(oh(exp_col[1])));
        RESET = 1'b1;
        step();
        check("t6_en",   32'(en_vec()), 0);
        check("t6_busy", 32'(bus.BUSY), 0);
        check("t6_len",  32'(bus.LEN), 0);
        check("t6_done", 32'(bus.DONE), 0);
        RESET = 1'b0;
        rd_check(0, 2'b00, "t6_rd");
        done_any = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) done_any = 1'b1;
            step();
        end
        check("t6_quiet", 32'(done_any), 0);

        // CLEAR beats EXTEND, EXTEND beats PLAY
        bus.EXTEND = 1'b1;
        step();
        bus.EXTEND = 1'b0;
        check("t5_len_one", 32'(bus.LEN), 1);
        bus.EXTEND = 1'b1;
        bus.CLEAR  = 1'b1;
        step();
        bus.EXTEND = 1'b0;
        bus.CLEAR  = 1'b0;
        check("t5_clear_wins", 32'(bus.LEN), 0);
        bus.EXTEND = 1'b1;
        bus.PLAY   = 1'b1;
        step();
        bus.EXTEND = 1'b0;
        bus.PLAY   = 1'b0;
        check("t5_ext_wins_len",  32'(bus.LEN), 1);
        check("t5_ext_wins_busy", 32'(bus.BUSY), 0);
        check("t5_ext_wins_done", 32'(bus.DONE), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
